// File: rtl/fifo_pkg.sv
// Shared constants and flag bundle for the threshold-aware output FIFO.
// Imported by the storage array and the FIFO control logic.
`timescale 1ns/1ps
package fifo_pkg;

  localparam int DATA_WIDTH = 6;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

  // Status flags that are all registered together from the next-state count.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/ram_dual_fifo.sv
// Register-array storage: one synchronous write port and one registered read port.
// The array itself is never reset; only the read register is cleared.
`timescale 1ns/1ps
module ram_dual_fifo
  import fifo_pkg::*;
#(
  parameter int DW = fifo_pkg::DATA_WIDTH,
  parameter int AW = fifo_pkg::ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A read on the same edge as a write to the same slot returns the old word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (clr) begin
      rd_data_d = '0;
    end else if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_umbrales.sv
// Output FIFO with programmable almost-full / almost-empty watermarks and a
// sticky overflow/underflow error; its empty flag feeds the flow-control FSM.
`timescale 1ns/1ps
module fifo_umbrales
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] umbral_alto,
  input  logic [ADDR_WIDTH-1:0] umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(2 ** ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  error_q, error_d;
  logic                  valid_q, valid_d;
  fifo_flags_t           flags_q, flags_d;
  logic                  sampled_q;
  logic                  push_ok;
  logic                  pop_ok;

  // Pop never bypasses an empty FIFO; push into a full FIFO only succeeds
  // when a pop frees the slot on the same edge. init overrides both.
  always_comb begin
    pop_ok  = pop && !flags_q.empty && !init;
    push_ok = push && (!flags_q.full || pop_ok) && !init;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q;
    valid_d  = 1'b0;

    if (init) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      error_d  = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      error_d = error_q
              | (push && flags_q.full && !pop_ok)
              | (pop && flags_q.empty);
      valid_d = pop_ok;
    end

    flags_d.empty        = (count_d == '0);
    flags_d.full         = (count_d == DEPTH_C);
    flags_d.almost_full  = (count_d >= {1'b0, umbral_alto});
    flags_d.almost_empty = (count_d <= {1'b0, umbral_bajo});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
      valid_q   <= 1'b0;
      flags_q   <= '{empty: 1'b1, full: 1'b0, almost_full: 1'b0, almost_empty: 1'b1};
      sampled_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      error_q   <= error_d;
      valid_q   <= valid_d;
      flags_q   <= flags_d;
      sampled_q <= 1'b1;
    end
  end

  ram_dual_fifo #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .clr     (init),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

  // Until the first edge after reset the registered almost_full has not seen
  // the threshold, so an empty FIFO reports it straight from umbral_alto.
  assign almost_full  = sampled_q ? flags_q.almost_full : (umbral_alto == '0);
  assign almost_empty = flags_q.almost_empty;
  assign empty        = flags_q.empty;
  assign full         = flags_q.full;
  assign error        = error_q;
  assign valid_out    = valid_q;
  assign count        = count_q;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Directed bench for fifo_umbrales: a reference queue feeds a scoreboard and
// a negedge monitor compares every valid_out word against it.
`timescale 1ns/1ps
module tb_fifo_umbrales;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [2:0] umbral_alto;
  logic [2:0] umbral_bajo;
  logic [5:0] data_out;
  logic       valid_out;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic       error;
  logic [3:0] count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [5:0] model [$];
  logic [5:0] exp_q [$];

  fifo_umbrales dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus; the reference queue decides what the DUT must accept.
  task automatic cycle(input logic p, input logic [5:0] d, input logic q);
    bit acc_pop;
    bit acc_push;
    acc_pop  = q && (model.size() > 0);
    acc_push = p && ((model.size() < 8) || acc_pop);
    push     = p;
    data_in  = d;
    pop      = q;
    if (acc_pop)  exp_q.push_back(model.pop_front());
    if (acc_push) model.push_back(d);
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic init_pulse();
    init = 1'b1;
    model.delete();
    @(posedge clk);
    #1;
    init = 1'b0;
  endtask

  initial begin : monitor
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_valid: got data_out %0d, expected no valid word", data_out);
        end else begin
          e = exp_q.pop_front();
          check("data_out", int'(data_out), int'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin : stimulus
    reset       = 1'b1;
    init        = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    data_in     = '0;
    umbral_alto = 3'd6;
    umbral_bajo = 3'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_almost_empty", int'(almost_empty), 1);
    check("rst_almost_full", int'(almost_full), 0);
    check("rst_full", int'(full), 0);
    check("rst_error", int'(error), 0);
    check("rst_valid", int'(valid_out), 0);
    check("rst_data_out", int'(data_out), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill 0x01..0x08, then drain in order.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 6'(i), 1'b0);
      check("fill_count", int'(count), i);
      check("fill_almost_full", int'(almost_full), int'(i >= 6));
      check("fill_full", int'(full), int'(i == 8));
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 6'd0, 1'b1);
      check("drain_count", int'(count), 7 - i);
      check("drain_almost_empty", int'(almost_empty), int'((7 - i) <= 2));
      check("drain_valid", int'(valid_out), 1);
    end
    check("drain_empty", int'(empty), 1);

    // Overflow: 0x3F must be dropped.
    for (int i = 0; i < 8; i++) cycle(1'b1, 6'(16 + i), 1'b0);
    cycle(1'b1, 6'h3F, 1'b0);
    check("ovf_error", int'(error), 1);
    check("ovf_count", int'(count), 8);
    check("ovf_full", int'(full), 1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 6'd0, 1'b1);
    check("ovf_drain_count", int'(count), 0);
    check("ovf_error_sticky", int'(error), 1);
    init_pulse();
    check("init_error", int'(error), 0);
    check("init_count", int'(count), 0);

    // Full with simultaneous push+pop, then wrap the pointers.
    for (int i = 0; i < 8; i++) cycle(1'b1, 6'(32 + i), 1'b0);
    cycle(1'b1, 6'h2A, 1'b1);
    check("fullpp_count", int'(count), 8);
    check("fullpp_oldest", int'(data_out), 'h20);
    check("fullpp_error", int'(error), 0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 6'(48 + i), 1'b1);
      check("wrap_count", int'(count), 8);
      check("wrap_error", int'(error), 0);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 6'd0, 1'b1);
    check("wrap_empty", int'(empty), 1);

    // Underflow, then push+pop while empty.
    cycle(1'b0, 6'd0, 1'b1);
    check("udf_valid", int'(valid_out), 0);
    check("udf_error", int'(error), 1);
    check("udf_count", int'(count), 0);
    init_pulse();
    check("init2_error", int'(error), 0);
    check("init2_empty", int'(empty), 1);
    cycle(1'b1, 6'h05, 1'b1);
    check("emptypp_count", int'(count), 1);
    check("emptypp_error", int'(error), 1);
    check("emptypp_valid", int'(valid_out), 0);
    init_pulse();
    check("init3_count", int'(count), 0);

    // Threshold change at count 3.
    for (int i = 0; i < 3; i++) cycle(1'b1, 6'(17 + i), 1'b0);
    check("thr_count", int'(count), 3);
    check("thr_ae_before", int'(almost_empty), 0);
    umbral_bajo = 3'd4;
    #1;
    check("thr_ae_not_yet", int'(almost_empty), 0);
    @(posedge clk);
    #1;
    check("thr_ae_after", int'(almost_empty), 1);

    // Reset in the middle of a push+pop burst.
    cycle(1'b1, 6'h21, 1'b1);
    cycle(1'b1, 6'h22, 1'b1);
    push        = 1'b1;
    pop         = 1'b1;
    umbral_alto = 3'd0;
    #1;
    reset = 1'b1;
    exp_q.delete();
    model.delete();
    #1;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_empty", int'(empty), 1);
    check("mid_rst_full", int'(full), 0);
    check("mid_rst_valid", int'(valid_out), 0);
    check("mid_rst_data_out", int'(data_out), 0);
    check("mid_rst_almost_empty", int'(almost_empty), 1);
    check("mid_rst_almost_full", int'(almost_full), 1);
    push = 1'b0;
    pop  = 1'b0;
    @(negedge clk);
    reset       = 1'b0;
    umbral_alto = 3'd6;
    @(posedge clk);
    #1;
    check("post_rst_count", int'(count), 0);
    check("post_rst_almost_full", int'(almost_full), 0);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
